dmem_responder: RTL and testbench

Slave end of the core's data-memory interface. It accepts the core's registered-input dmem requests and serves them from an on-chip byte-enable RAM, or forwards them to an external peripheral bus with a wait-state handshake. It returns right-aligned read data and drives dmem_wait so the core pipeline stalls during slow accesses. It sits beside the core at top level, one instance per core.

---
 rtl/dmem_pkg.sv | 62 ++++++
 rtl/dmem_responder_if.sv | 37 +++
 rtl/dmem_ram.sv | 31 +++
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access modes,
// responder FSM states and byte-lane steering functions.
package dmem_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    IDLE,
    EXT_BUSY
  } dmem_state_t;

  function automatic logic [3:0] byte_enable(input logic [2:0] mode, input logic [1:0] off);
    case (mode)
      MODE_B, MODE_BU: byte_enable = 4'b0001 << off;
      MODE_H, MODE_HU: byte_enable = 4'b0011 << {off[1], 1'b0};
      default:         byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [2:0] mode, input logic [31:0] data);
    case (mode)
      MODE_B, MODE_BU: replicate_wdata = {4{data[7:0]}};
      MODE_H, MODE_HU: replicate_wdata = {2{data[15:0]}};
      default:         replicate_wdata = data;
    endcase
  endfunction

  // Shift the addressed byte/half down to bit 0; sign extension is the core's job.
  function automatic logic [31:0] align_rdata(input logic [2:0] mode, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    case (mode)
      MODE_B, MODE_BU: begin
        sh          = word >> {off, 3'b000};
        align_rdata = {24'h0, sh[7:0]};
      end
      MODE_H, MODE_HU: begin
        sh          = word >> {off[1], 4'b0000};
        align_rdata = {16'h0, sh[15:0]};
      end
      default: begin
        sh          = word;
        align_rdata = sh;
      end
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
    case (mode)
      MODE_H, MODE_HU: is_misaligned = off[0];
      MODE_W:          is_misaligned = (off != 2'b00);
      default:         is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory request/response signals plus the external peripheral bus
// handshake, bundled for the responder.
interface dmem_responder_if;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic [31:0] dmem_write_data;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;

  logic        ext_req;
  logic [31:0] ext_addr;
  logic        ext_we;
  logic [3:0]  ext_be;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  modport slave (
    input  dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
           dmem_write_mode, dmem_read_enable, dmem_read_mode,
    output dmem_read_data, dmem_wait,
    output ext_req, ext_addr, ext_we, ext_be, ext_wdata,
    input  ext_ack, ext_rdata
  );

  modport master (
    output dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
           dmem_write_mode, dmem_read_enable, dmem_read_mode,
    input  dmem_read_data, dmem_wait,
    input  ext_req, ext_addr, ext_we, ext_be, ext_wdata,
    output ext_ack, ext_rdata
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables and a
// registered read port that only updates when re is high.
module dmem_ram #(
  parameter int WORDS = 4096
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [3:0]               we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  // One array per byte lane so each lane is a plain write-enabled block RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        mem[addr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        rdata_q <= mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = rdata_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: serves core loads/stores from on-chip RAM or an external
// wait-state bus. Optional misalignment trapping: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS = 4096,
  parameter logic [31:0] EXT_BASE  = 32'h8000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dmem_responder_if.slave        bus,
  output logic                   bus_error,
  output logic                   align_error
);

  localparam int AW    = $clog2(RAM_WORDS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT - 1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             src_ram_q, src_ram_d;
  logic [2:0]       rd_mode_q, rd_mode_d;
  logic [1:0]       rd_off_q, rd_off_d;
  logic             ext_req_q, ext_req_d;
  logic             ext_we_q, ext_we_d;
  logic [3:0]       ext_be_q, ext_be_d;
  logic [31:0]      ext_addr_q, ext_addr_d;
  logic [31:0]      ext_wdata_q, ext_wdata_d;
  logic             bus_error_q, bus_error_d;
  logic             align_error_q, align_error_d;

  logic        req;
  logic        is_write;
  logic [2:0]  eff_mode;
  logic [1:0]  off;
  logic        is_ext;
  logic        misaligned;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign req      = bus.dmem_enable && (bus.dmem_read_enable || bus.dmem_write_enable);
  assign is_write = bus.dmem_write_enable;
  assign eff_mode = is_write ? bus.dmem_write_mode : bus.dmem_read_mode;
  assign off      = bus.dmem_address[1:0];
  assign is_ext   = (bus.dmem_address >= EXT_BASE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(eff_mode, off);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rdata_d       = rdata_q;
    src_ram_d     = src_ram_q;
    rd_mode_d     = rd_mode_q;
    rd_off_d      = rd_off_q;
    ext_req_d     = ext_req_q;
    ext_we_d      = ext_we_q;
    ext_be_d      = ext_be_q;
    ext_addr_d    = ext_addr_q;
    ext_wdata_d   = ext_wdata_q;
    bus_error_d   = bus_error_q;
    align_error_d = align_error_q;
    ram_we        = 4'b0000;
    ram_re        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          rd_mode_d = bus.dmem_read_mode;
          rd_off_d  = off;
          if (misaligned) begin
            rdata_d       = 32'h0;
            src_ram_d     = 1'b0;
            align_error_d = 1'b1;
          end else if (is_ext) begin
            state_d     = EXT_BUSY;
            count_d     = '0;
            ext_req_d   = 1'b1;
            ext_we_d    = is_write;
            ext_be_d    = byte_enable(eff_mode, off);
            ext_addr_d  = {bus.dmem_address[31:2], 2'b00};
            ext_wdata_d = is_write ? replicate_wdata(eff_mode, bus.dmem_write_data) : 32'h0;
          end else begin
            // Stores (including write-wins collisions) return zero read data.
            ram_we    = is_write ? byte_enable(eff_mode, off) : 4'b0000;
            ram_re    = !is_write;
            src_ram_d = !is_write;
            rdata_d   = 32'h0;
          end
        end
      end
      EXT_BUSY: begin
        if (bus.ext_ack) begin
          state_d   = IDLE;
          ext_req_d = 1'b0;
          src_ram_d = 1'b0;
          rdata_d   = ext_we_q ? 32'h0 : align_rdata(rd_mode_q, rd_off_q, bus.ext_rdata);
        end else if (count_q == COUNT_LAST) begin
          state_d     = IDLE;
          ext_req_d   = 1'b0;
          src_ram_d   = 1'b0;
          rdata_d     = TIMEOUT_DATA;
          bus_error_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      rdata_q       <= 32'h0;
      src_ram_q     <= 1'b0;
      rd_mode_q     <= MODE_W;
      rd_off_q      <= 2'b00;
      ext_req_q     <= 1'b0;
      ext_we_q      <= 1'b0;
      ext_be_q      <= 4'b0000;
      ext_addr_q    <= 32'h0;
      ext_wdata_q   <= 32'h0;
      bus_error_q   <= 1'b0;
      align_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rdata_q       <= rdata_d;
      src_ram_q     <= src_ram_d;
      rd_mode_q     <= rd_mode_d;
      rd_off_q      <= rd_off_d;
      ext_req_q     <= ext_req_d;
      ext_we_q      <= ext_we_d;
      ext_be_q      <= ext_be_d;
      ext_addr_q    <= ext_addr_d;
      ext_wdata_q   <= ext_wdata_d;
      bus_error_q   <= bus_error_d;
      align_error_q <= align_error_d;
    end
  end

  dmem_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (bus.dmem_address[AW+1:2]),
    .wdata (replicate_wdata(eff_mode, bus.dmem_write_data)),
    .rdata (ram_rdata)
  );

  // RAM reads are aligned on the way out so the RAM output register doubles as the load register.
  assign bus.dmem_read_data = src_ram_q ? align_rdata(rd_mode_q, rd_off_q, ram_rdata) : rdata_q;
  assign bus.dmem_wait      = (state_q == EXT_BUSY);
  assign bus.ext_req        = ext_req_q;
  assign bus.ext_we         = ext_we_q;
  assign bus.ext_be         = ext_be_q;
  assign bus.ext_addr       = ext_addr_q;
  assign bus.ext_wdata      = ext_wdata_q;
  assign bus_error          = bus_error_q;
  assign align_error        = align_error_q;

  // The core must hold off new requests while it is being stalled.
  a_no_req_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == EXT_BUSY) |-> !(bus.dmem_enable && (bus.dmem_read_enable || bus.dmem_write_enable)));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM path, external bus
// handshake, timeout, reset abort and the optional alignment check.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk;
  logic reset_n;
  logic bus_error;
  logic align_error;
  int   total;
  int   bad;

  dmem_responder_if bus();

  dmem_responder #(
    .RAM_WORDS (4096),
    .EXT_BASE  (32'h8000_0000),
    .TIMEOUT   (255)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .bus_error   (bus_error),
    .align_error (align_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request for a single edge, starting and ending just after a negedge.
  task automatic issue(input logic we, input logic re, input logic [2:0] wm, input logic [2:0] rm,
                       input logic [31:0] a, input logic [31:0] d);
    bus.dmem_enable       = 1'b1;
    bus.dmem_write_enable = we;
    bus.dmem_read_enable  = re;
    bus.dmem_write_mode   = wm;
    bus.dmem_read_mode    = rm;
    bus.dmem_address      = a;
    bus.dmem_write_data   = d;
    @(negedge clk);
    bus.dmem_enable       = 1'b0;
    bus.dmem_write_enable = 1'b0;
    bus.dmem_read_enable  = 1'b0;
    $display("txn we=%0d re=%0d addr=%h wdata=%h -> rdata=%h wait=%0d", we, re, a, d,
             bus.dmem_read_data, bus.dmem_wait);
  endtask

  // Act as the external slave: ack in the ack_cycle-th cycle of the stall (0 = never).
  task automatic ext_serve(input int ack_cycle, input logic [31:0] rdata, output int high_cycles);
    high_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.dmem_wait) break;
      high_cycles++;
      if (high_cycles == ack_cycle) begin
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = rdata;
      end
      @(negedge clk);
      bus.ext_ack   = 1'b0;
      bus.ext_rdata = 32'h0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.dmem_read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.dmem_read_data); end
    total++; if (bus.dmem_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b want=0", bus.dmem_wait); end
    total++; if (bus.ext_req !== 1'b0) begin bad++; $display("FAIL reset_ext_req got=%b want=0", bus.ext_req); end
    total++; if (bus.ext_we !== 1'b0) begin bad++; $display("FAIL reset_ext_we got=%b want=0", bus.ext_we); end
    total++; if (bus.ext_be !== 4'h0) begin bad++; $display("FAIL reset_ext_be got=%h want=0", bus.ext_be); end
    total++; if (bus.ext_addr !== 32'h0) begin bad++; $display("FAIL reset_ext_addr got=%h want=0", bus.ext_addr); end
    total++; if (bus.ext_wdata !== 32'h0) begin bad++; $display("FAIL reset_ext_wdata got=%h want=0", bus.ext_wdata); end
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL reset_bus_error got=%b want=0", bus_error); end
    total++; if (align_error !== 1'b0) begin bad++; $display("FAIL reset_align_error got=%b want=0", align_error); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_word();
    issue(1'b1, 1'b0, MODE_W, MODE_W, 32'h0000_0100, 32'h1122_3344);
    total++; if (bus.dmem_wait !== 1'b0) begin bad++; $display("FAIL sw_wait got=%b want=0", bus.dmem_wait); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0100, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h1122_3344) begin bad++; $display("FAIL lw_100 got=%h want=11223344", bus.dmem_read_data); end
    total++; if (bus.dmem_wait !== 1'b0) begin bad++; $display("FAIL lw_wait got=%b want=0", bus.dmem_wait); end
    // Enable low with other inputs wiggling: read data must hold.
    bus.dmem_read_enable = 1'b1;
    bus.dmem_address     = 32'h0000_0200;
    @(negedge clk);
    bus.dmem_read_enable = 1'b0;
    total++; if (bus.dmem_read_data !== 32'h1122_3344) begin bad++; $display("FAIL hold_rdata got=%h want=11223344", bus.dmem_read_data); end
    // Word index wraps at RAM_WORDS: 0x4100 aliases 0x100.
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_4100, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h1122_3344) begin bad++; $display("FAIL lw_wrap got=%h want=11223344", bus.dmem_read_data); end
    // Highest address below EXT_BASE stays in RAM.
    issue(1'b1, 1'b0, MODE_W, MODE_W, 32'h7FFF_FFFC, 32'h0102_0304);
    total++; if (bus.dmem_wait !== 1'b0) begin bad++; $display("FAIL below_base_wait got=%b want=0", bus.dmem_wait); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_3FFC, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h0102_0304) begin bad++; $display("FAIL below_base_rd got=%h want=01020304", bus.dmem_read_data); end
  endtask

  task automatic test_ram_subword();
    issue(1'b1, 1'b0, MODE_B, MODE_W, 32'h0000_0103, 32'hFFFF_FFAB);
    issue(1'b0, 1'b1, MODE_W, MODE_BU, 32'h0000_0103, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_103 got=%h want=000000ab", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0100, 32'h0);
    total++; if (bus.dmem_read_data !== 32'hAB22_3344) begin bad++; $display("FAIL lw_after_sb got=%h want=ab223344", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_HU, 32'h0000_0102, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h0000_AB22) begin bad++; $display("FAIL lhu_102 got=%h want=0000ab22", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_B, 32'h0000_0101, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h0000_0033) begin bad++; $display("FAIL lb_101 got=%h want=00000033", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_H, 32'h0000_0100, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h0000_3344) begin bad++; $display("FAIL lh_100 got=%h want=00003344", bus.dmem_read_data); end
    issue(1'b1, 1'b0, MODE_H, MODE_W, 32'h0000_0100, 32'h1234_5566);
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0100, 32'h0);
    total++; if (bus.dmem_read_data !== 32'hAB22_5566) begin bad++; $display("FAIL sh_merge got=%h want=ab225566", bus.dmem_read_data); end
  endtask

  task automatic test_write_wins();
    issue(1'b1, 1'b1, MODE_W, MODE_W, 32'h0000_0200, 32'h5566_7788);
    total++; if (bus.dmem_read_data !== 32'h0) begin bad++; $display("FAIL both_rdata got=%h want=0", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0200, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h5566_7788) begin bad++; $display("FAIL both_written got=%h want=55667788", bus.dmem_read_data); end
  endtask

  task automatic test_ext_read();
    int n;
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h8000_0010, 32'h0);
    total++; if (bus.ext_req !== 1'b1) begin bad++; $display("FAIL ext_rd_req got=%b want=1", bus.ext_req); end
    total++; if (bus.ext_addr !== 32'h8000_0010) begin bad++; $display("FAIL ext_rd_addr got=%h want=80000010", bus.ext_addr); end
    total++; if (bus.ext_be !== 4'hF) begin bad++; $display("FAIL ext_rd_be got=%h want=f", bus.ext_be); end
    total++; if (bus.ext_we !== 1'b0) begin bad++; $display("FAIL ext_rd_we got=%b want=0", bus.ext_we); end
    ext_serve(3, 32'hCAFE_F00D, n);
    total++; if (n !== 3) begin bad++; $display("FAIL ext_rd_wait_cycles got=%0d want=3", n); end
    total++; if (bus.ext_req !== 1'b0) begin bad++; $display("FAIL ext_rd_req_drop got=%b want=0", bus.ext_req); end
    total++; if (bus.dmem_read_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL ext_rd_data got=%h want=cafef00d", bus.dmem_read_data); end
    // A stray ack while idle must be ignored.
    bus.ext_ack   = 1'b1;
    bus.ext_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = 32'h0;
    total++; if (bus.dmem_read_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL idle_ack got=%h want=cafef00d", bus.dmem_read_data); end
    total++; if (bus.dmem_wait !== 1'b0) begin bad++; $display("FAIL idle_ack_wait got=%b want=0", bus.dmem_wait); end
    issue(1'b0, 1'b1, MODE_W, MODE_BU, 32'h8000_0021, 32'h0);
    total++; if (bus.ext_be !== 4'b0010) begin bad++; $display("FAIL ext_lbu_be got=%b want=0010", bus.ext_be); end
    ext_serve(2, 32'h11AA_2233, n);
    total++; if (bus.dmem_read_data !== 32'h0000_0022) begin bad++; $display("FAIL ext_lbu_data got=%h want=00000022", bus.dmem_read_data); end
  endtask

  task automatic test_ext_write();
    int n;
    issue(1'b1, 1'b0, MODE_H, MODE_W, 32'h8000_0006, 32'h1234_BEEF);
    total++; if (bus.ext_we !== 1'b1) begin bad++; $display("FAIL ext_wr_we got=%b want=1", bus.ext_we); end
    total++; if (bus.ext_be !== 4'b1100) begin bad++; $display("FAIL ext_wr_be got=%b want=1100", bus.ext_be); end
    total++; if (bus.ext_wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL ext_wr_wdata got=%h want=beefbeef", bus.ext_wdata); end
    total++; if (bus.ext_addr !== 32'h8000_0004) begin bad++; $display("FAIL ext_wr_addr got=%h want=80000004", bus.ext_addr); end
    ext_serve(1, 32'h0, n);
    total++; if (n !== 1) begin bad++; $display("FAIL ext_wr_wait_cycles got=%0d want=1", n); end
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h8000_0000, 32'h0);
    ext_serve(0, 32'h0, n);
    total++; if (n !== 255) begin bad++; $display("FAIL to_cycles got=%0d want=255", n); end
    total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL to_bus_error got=%b want=1", bus_error); end
    total++; if (bus.dmem_read_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_rdata got=%h want=deadbeef", bus.dmem_read_data); end
    total++; if (bus.dmem_wait !== 1'b0) begin bad++; $display("FAIL to_wait got=%b want=0", bus.dmem_wait); end
    // Rerun, then abort with reset partway through the stall.
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h8000_0000, 32'h0);
    repeat (5) @(negedge clk);
    total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", bus_error); end
    total++; if (bus.ext_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b want=1", bus.ext_req); end
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (bus.ext_req !== 1'b0) begin bad++; $display("FAIL rst_ext_req got=%b want=0", bus.ext_req); end
    total++; if (bus.dmem_wait !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b want=0", bus.dmem_wait); end
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL rst_bus_error got=%b want=0", bus_error); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_align();
    issue(1'b1, 1'b0, MODE_W, MODE_W, 32'h0000_0100, 32'h0BAD_F00D);
    issue(1'b1, 1'b0, MODE_W, MODE_W, 32'h0000_0101, 32'h9999_9999);
`ifdef DMEM_ALIGN_CHECK_EN
    total++; if (align_error !== 1'b1) begin bad++; $display("FAIL align_flag got=%b want=1", align_error); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0100, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL align_nowrite got=%h want=0badf00d", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0102, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h0) begin bad++; $display("FAIL align_lw got=%h want=0", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h8000_0002, 32'h0);
    total++; if (bus.ext_req !== 1'b0) begin bad++; $display("FAIL align_ext_req got=%b want=0", bus.ext_req); end
`else
    total++; if (align_error !== 1'b0) begin bad++; $display("FAIL align_flag got=%b want=0", align_error); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0100, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h9999_9999) begin bad++; $display("FAIL align_write got=%h want=99999999", bus.dmem_read_data); end
    issue(1'b0, 1'b1, MODE_W, MODE_W, 32'h0000_0102, 32'h0);
    total++; if (bus.dmem_read_data !== 32'h9999_9999) begin bad++; $display("FAIL align_lw got=%h want=99999999", bus.dmem_read_data); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n               = 1'b0;
    bus.dmem_address      = 32'h0;
    bus.dmem_enable       = 1'b0;
    bus.dmem_write_data   = 32'h0;
    bus.dmem_write_enable = 1'b0;
    bus.dmem_write_mode   = MODE_W;
    bus.dmem_read_enable  = 1'b0;
    bus.dmem_read_mode    = MODE_W;
    bus.ext_ack           = 1'b0;
    bus.ext_rdata         = 32'h0;
    @(negedge clk);
    test_reset();
    test_ram_word();
    test_ram_subword();
    test_write_wins();
    test_ext_read();
    test_ext_write();
    test_timeout();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
